// File: rtl/seg7_capture_debug.sv
// seg7_capture_debug: demultiplexes a time-multiplexed MCU 7-segment stream
// into static per-digit registers, with glitch filtering, stale-digit blanking
// and a paged hex debug view of a wide word.

// One display digit: captured pattern, staleness timer and output register.
module seg7_digit_lane #(
  parameter int STALE_CYCLES = 1048576,
  parameter bit DP_KEEP_BIT  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       latch_en,
  input  logic [7:0] latch_val,
  input  logic       debug_en,
  input  logic [7:0] dbg_glyph,
  output logic [7:0] seg,
  output logic       stale
);
  localparam int STW = $clog2(STALE_CYCLES + 1);
  localparam logic [STW-1:0] STALE_MAX = STW'(STALE_CYCLES);

  logic [7:0]     cap_q, cap_d;
  logic [7:0]     seg_q, seg_d;
  logic [STW-1:0] age_q, age_d;
  logic           stale_q, stale_d;

  // Latch wins over blanking; the output register sees the post-update cap so
  // a blank appears on the same edge the timer saturates.
  always_comb begin
    cap_d   = cap_q;
    age_d   = age_q;
    stale_d = stale_q;
    if (latch_en) begin
      cap_d   = DP_KEEP_BIT ? latch_val : (latch_val | 8'h01);
      age_d   = '0;
      stale_d = 1'b0;
    end else begin
      if (age_q != STALE_MAX) age_d = age_q + 1'b1;
      if (age_d == STALE_MAX) begin
        cap_d   = 8'hFF;
        stale_d = 1'b1;
      end
    end
    seg_d = debug_en ? dbg_glyph : cap_d;
  end

  // Lane state; reset shows a blank, stale digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q   <= 8'hFF;
      seg_q   <= 8'hFF;
      age_q   <= '0;
      stale_q <= 1'b1;
    end else begin
      cap_q   <= cap_d;
      seg_q   <= seg_d;
      age_q   <= age_d;
      stale_q <= stale_d;
    end
  end

  assign seg   = seg_q;
  assign stale = stale_q;
endmodule

// Top: shared stability filter and debug glyph generation, one lane per digit.
module seg7_capture_debug #(
  parameter int               DIGITS        = 4,
  parameter int               STABLE_CYCLES = 4,
  parameter int               STALE_CYCLES  = 1048576,
  parameter int               DEBUG_W       = 32,
  parameter logic [DIGITS-1:0] DP_KEEP      = DIGITS'(1),
  localparam int              NPP           = 4 * DIGITS,
  localparam int              PAGES         = (DEBUG_W + NPP - 1) / NPP,
  localparam int              PW            = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   debug_en,
  input  logic [7:0]             mcu_seg,
  input  logic [DIGITS-1:0]      mcu_digit,
  input  logic [DEBUG_W-1:0]     debug_value,
  input  logic [PW-1:0]          debug_page,
  output logic [DIGITS-1:0][7:0] seg,
  output logic [DIGITS-1:0]      stale,
  output logic                   debug_active
);
  localparam int SW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int PADW = PAGES * NPP;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  // Active-low {a,b,c,d,e,f,g,h} hex glyphs, dot off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 8'h03;
      4'h1: hex_glyph = 8'h9F;
      4'h2: hex_glyph = 8'h25;
      4'h3: hex_glyph = 8'h0D;
      4'h4: hex_glyph = 8'h99;
      4'h5: hex_glyph = 8'h49;
      4'h6: hex_glyph = 8'h41;
      4'h7: hex_glyph = 8'h1F;
      4'h8: hex_glyph = 8'h01;
      4'h9: hex_glyph = 8'h09;
      4'hA: hex_glyph = 8'h11;
      4'hB: hex_glyph = 8'hC1;
      4'hC: hex_glyph = 8'h63;
      4'hD: hex_glyph = 8'h85;
      4'hE: hex_glyph = 8'h61;
      default: hex_glyph = 8'h71;
    endcase
  endfunction

  logic [DIGITS+7:0]        prev_q, prev_d;
  logic [SW-1:0]            stab_q, stab_d;
  logic                     debug_active_q, debug_active_d;
  logic [DIGITS-1:0]        prev_dig;
  logic                     latch_ok;
  logic [DIGITS-1:0]        latch_en;
  logic [PADW-1:0]          dbg_pad;
  logic [NPP-1:0]           dbg_win;
  logic                     page_ok;
  logic [DIGITS-1:0][7:0]   dbg_glyph;

  // Stability run: restart on any bit change, saturate once long enough.
  always_comb begin
    prev_d = {mcu_digit, mcu_seg};
    stab_d = stab_q;
    if (prev_d != prev_q)       stab_d = '0;
    else if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
    debug_active_d = debug_en;
  end

  // Filter state; previous sample resets to all ones so the first real sample
  // after release starts a fresh run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q         <= '1;
      stab_q         <= '0;
      debug_active_q <= 1'b0;
    end else begin
      prev_q         <= prev_d;
      stab_q         <= stab_d;
      debug_active_q <= debug_active_d;
    end
  end

  // Latch the held sample into the one digit selected low, only when exactly
  // one select bit is low.
  always_comb begin
    prev_dig = prev_q[DIGITS+7:8];
    latch_ok = (stab_q == STAB_MAX) && $onehot(~prev_dig);
    latch_en = latch_ok ? ~prev_dig : '0;
  end

  assign dbg_pad = PADW'(debug_value);

  // Pick the page window (bits past DEBUG_W are zero-padded) and make glyphs;
  // an out-of-range page blanks every digit, digit 0 shows a dot otherwise.
  always_comb begin
    dbg_win = '0;
    page_ok = 1'b0;
    for (int p = 0; p < PAGES; p++) begin
      if (debug_page == PW'(p)) begin
        dbg_win = dbg_pad[p*NPP +: NPP];
        page_ok = 1'b1;
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
      dbg_glyph[k] = page_ok ? hex_glyph(dbg_win[4*k +: 4]) : 8'hFF;
    end
    if (page_ok) dbg_glyph[0][0] = 1'b0;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    seg7_digit_lane #(
      .STALE_CYCLES(STALE_CYCLES),
      .DP_KEEP_BIT (DP_KEEP[i])
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .latch_en (latch_en[i]),
      .latch_val(prev_q[7:0]),
      .debug_en (debug_en),
      .dbg_glyph(dbg_glyph[i]),
      .seg      (seg[i]),
      .stale    (stale[i])
    );
  end

  assign debug_active = debug_active_q;
endmodule
